ysyx_23060020_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060020_mem_arbiter

Overview:
Shares the single core memory port between instruction fetch (IFU) and load/store (LSU) masters in the multi-cycle ysyx_23060020 core. Accepts one request at a time via valid/ready handshakes, forwards it to memory, and routes the response back to the owning master. At most one transaction is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (mask width = DATA_W/8)
PRIO_LSU, 1, 1 = LSU wins ties; 0 = round-robin
TIMEOUT, 255, response watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  IFU response strobe
ifu_rdata  out  DATA_W  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = write
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte enables
lsu_resp_valid  out  1  LSU response strobe
lsu_rdata  out  DATA_W  LSU read data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable (0 for IFU)
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered mask (0 for IFU)
mem_resp_valid  in  1  memory response strobe
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE
resp_err  out  1  present only with ARB_TIMEOUT_EN; see below

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=none, last_owner=LSU, all outputs 0, payload registers 0.
- States: IDLE -> REQ -> RESP -> IDLE.
- IDLE: winner selected combinationally from the two valid inputs. Only the winner's req_ready is 1. Accept occurs on valid&ready: payload and owner are latched, and the next state is REQ. With no valid input, stay in IDLE.
- Tie arbitration: PRIO_LSU=1 -> LSU wins. PRIO_LSU=0 -> the master that is not last_owner wins. last_owner updates at every accept. The first tie after reset goes to IFU.
- REQ: mem_req_valid=1 with stable payload. Go to RESP when mem_req_ready=1. Latency: accept at cycle N, mem_req_valid first high at N+1.
- RESP: when mem_resp_valid=1, the owner's resp_valid=1 in the same cycle. rdata is passthrough of mem_rdata. Next state is IDLE and owner is cleared. A new accept is possible the cycle after the response.
- The non-owner's resp_valid is always 0. Both rdata outputs show mem_rdata, qualified only by resp_valid.
- mem_resp_valid in IDLE or REQ is ignored. A mem_resp_valid in the same cycle as the REQ->RESP handshake is also ignored; the response is expected at the earliest one cycle later.
- Masters hold valid and payload stable until ready. Dropping valid before accept is legal and cancels the request.
- LSU write responses also use lsu_resp_valid; lsu_rdata is don't-care for writes.
- Reset mid-transaction returns to IDLE. Any later stray mem_resp_valid is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to RESP and increments each RESP cycle.
  - When it reaches TIMEOUT with no response, the owner's resp_valid=1, resp_err=1 and rdata=32'hDEADBEEF for one cycle, then the FSM goes to IDLE.
  - resp_err is 0 otherwise.
- Undefined: no counter and no resp_err port; RESP waits indefinitely.

Decomposition:
- Package ysyx_23060020_bus_pkg contains:
  - state encoding (IDLE/REQ/RESP)
  - owner encoding (NONE/IFU/LSU)
  - DEADBEEF constant
  - default TIMEOUT
- One sub-module: ysyx_23060020_rr_pick, the 2-way combinational picker with inputs valid[1:0], last_owner and prio_lsu, and a one-hot grant output.

Test Plan:
- IFU-only read, addr 0x80000000, mem_req_ready=1 at N+1, mem_resp_valid at N+3 with rdata 0x00100073 -> ifu_resp_valid=1 at N+3 with ifu_rdata 0x00100073; lsu_resp_valid stays 0.
- LSU write, addr 0x80001000, wdata 0x12345678, wmask 0xF -> mem_wen=1 and mem_wmask=0xF from N+1; lsu_resp_valid on response; ifu_ready=0 throughout.
- Both valid simultaneously:
  - PRIO_LSU=1 -> LSU granted twice in a row.
  - PRIO_LSU=0 -> IFU, then LSU, then IFU.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and payload stable; no second accept; busy=1.
- Reset asserted in RESP, then mem_resp_valid pulsed after reset release -> no resp_valid pulse; state IDLE.
- ARB_TIMEOUT_EN with TIMEOUT=4 and no response -> owner resp_valid=1, resp_err=1, rdata 0xDEADBEEF, 4 cycles after RESP entry; next request accepted normally.

Source files
------------

// File: rtl/ysyx_23060020_bus_pkg.sv
// Shared types and constants for the ysyx_23060020 memory arbiter.
//   arb_state_e : arbiter FSM states (idle / request to memory / waiting for response)
//   owner_e     : which master owns the in-flight transaction
//   DeadBeef    : read data returned on a response timeout
//   TimeoutDefault : default response watchdog limit in cycles
package ysyx_23060020_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIfu  = 2'd1,
    OwnLsu  = 2'd2
  } owner_e;

  localparam logic [31:0] DeadBeef       = 32'hDEADBEEF;
  localparam int unsigned TimeoutDefault = 255;

endpackage

// File: rtl/ysyx_23060020_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the memory port.
//   slave  : arbiter view (takes master requests and memory responses, drives the rest)
//   master : environment view (masters plus memory model)
interface ysyx_23060020_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // IFU side
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  // LSU side
  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_resp_valid;
  logic [DATA_W-1:0]   lsu_rdata;
  // Memory side
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/ysyx_23060020_rr_pick.sv
// Two-way combinational request picker.
//   valid_i[0] = IFU request, valid_i[1] = LSU request
//   last_owner_i : master that won the previous accept
//   prio_lsu_i   : 1 = LSU always wins a tie, 0 = alternate on ties
//   grant_o      : one-hot grant (bit 0 IFU, bit 1 LSU), zero when nothing is valid
module ysyx_23060020_rr_pick
  import ysyx_23060020_bus_pkg::*;
(
  input  logic [1:0] valid_i,
  input  owner_e     last_owner_i,
  input  logic       prio_lsu_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: fixed LSU priority, or hand the grant to whoever did not win last time.
      2'b11:   grant_o = (prio_lsu_i || (last_owner_i == OwnIfu)) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060020_mem_arbiter.sv
// Shares the single core memory port between the IFU and the LSU.
// One transaction in flight at a time: IDLE (arbitrate/accept) -> REQ (present to memory)
// -> RESP (wait for the response and route it to the owner) -> IDLE.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : ysyx_23060020_mem_arbiter_if.slave (master handshakes and memory port)
//   busy       : high whenever the FSM is not idle
//   resp_err   : only with ARB_TIMEOUT_EN; flags the forced response on a watchdog expiry
// Build option: define ARB_TIMEOUT_EN to add the response watchdog (TIMEOUT cycles in RESP).
module ysyx_23060020_mem_arbiter
  import ysyx_23060020_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter bit          PRIO_LSU = 1'b1,
  parameter int unsigned TIMEOUT  = TimeoutDefault
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060020_mem_arbiter_if.slave bus,
`ifdef ARB_TIMEOUT_EN
  output logic resp_err,
`endif
  output logic busy
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [1:0]          grant;
  logic                timeout_hit;
  logic                resp_fire;

  ysyx_23060020_rr_pick u_pick (
    .valid_i      ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last_owner_i (last_q),
    .prio_lsu_i   (PRIO_LSU),
    .grant_o      (grant)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StReq && bus.mem_req_ready) begin
      cnt_d = '0;
    end else if (state_q == StResp && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;  // saturates so it can never wrap past TIMEOUT
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // A real response in the same cycle takes precedence over the watchdog.
  assign timeout_hit = (state_q == StResp) && !bus.mem_resp_valid &&
                       (cnt_q == CntW'(TIMEOUT));
  assign resp_err    = timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Responses outside RESP (including the REQ->RESP handshake cycle) are dropped.
  assign resp_fire = (state_q == StResp) && (bus.mem_resp_valid || timeout_hit);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.mem_req_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.ifu_req_ready = grant[0];
        bus.lsu_req_ready = grant[1];
        if (grant[0]) begin
          owner_d = OwnIfu;
          last_d  = OwnIfu;
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = StReq;
        end else if (grant[1]) begin
          owner_d = OwnLsu;
          last_d  = OwnLsu;
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
          state_d = StReq;
        end
      end
      StReq: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = StResp;
      end
      StResp: begin
        if (resp_fire) begin
          owner_d = OwnNone;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      last_q  <= OwnLsu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign bus.ifu_resp_valid = resp_fire && (owner_q == OwnIfu);
  assign bus.lsu_resp_valid = resp_fire && (owner_q == OwnLsu);
  assign bus.ifu_rdata      = timeout_hit ? DATA_W'(DeadBeef) : bus.mem_rdata;
  assign bus.lsu_rdata      = timeout_hit ? DATA_W'(DeadBeef) : bus.mem_rdata;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_23060020_mem_arbiter.sv
// Directed bench for ysyx_23060020_mem_arbiter. Two instances share all stimulus:
// dut_a uses fixed LSU priority, dut_b round-robin; both use TIMEOUT=4.
module tb_ysyx_23060020_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060020_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  ysyx_23060020_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
  logic busy_a, busy_b;
`ifdef ARB_TIMEOUT_EN
  logic err_a, err_b;
`endif

  ysyx_23060020_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_LSU(1'b1), .TIMEOUT(4)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifa),
`ifdef ARB_TIMEOUT_EN
    .resp_err (err_a),
`endif
    .busy     (busy_a)
  );

  ysyx_23060020_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_LSU(1'b0), .TIMEOUT(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifb),
`ifdef ARB_TIMEOUT_EN
    .resp_err (err_b),
`endif
    .busy     (busy_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic lv,
                       input logic [31:0] la, input logic lw, input logic [31:0] wd,
                       input logic [3:0] wm, input logic mrr, input logic mrv,
                       input logic [31:0] rd);
    ifa.ifu_req_valid = iv;  ifb.ifu_req_valid = iv;
    ifa.ifu_addr      = ia;  ifb.ifu_addr      = ia;
    ifa.lsu_req_valid = lv;  ifb.lsu_req_valid = lv;
    ifa.lsu_addr      = la;  ifb.lsu_addr      = la;
    ifa.lsu_wen       = lw;  ifb.lsu_wen       = lw;
    ifa.lsu_wdata     = wd;  ifb.lsu_wdata     = wd;
    ifa.lsu_wmask     = wm;  ifb.lsu_wmask     = wm;
    ifa.mem_req_ready = mrr; ifb.mem_req_ready = mrr;
    ifa.mem_resp_valid = mrv; ifb.mem_resp_valid = mrv;
    ifa.mem_rdata     = rd;  ifb.mem_rdata     = rd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Outputs whose expectation is identical for both instances.
  task automatic check_both(input string t, input logic ird, input logic lrd, input logic mrv,
                            input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                            input logic [3:0] wm, input logic ir, input logic lr,
                            input logic bsy);
    chk({t, ".ifu_ready_a"}, ifa.ifu_req_ready, ird);
    chk({t, ".ifu_ready_b"}, ifb.ifu_req_ready, ird);
    chk({t, ".lsu_ready_a"}, ifa.lsu_req_ready, lrd);
    chk({t, ".lsu_ready_b"}, ifb.lsu_req_ready, lrd);
    chk({t, ".mem_req_valid_a"}, ifa.mem_req_valid, mrv);
    chk({t, ".mem_req_valid_b"}, ifb.mem_req_valid, mrv);
    chk({t, ".mem_addr_a"}, ifa.mem_addr, addr);
    chk({t, ".mem_addr_b"}, ifb.mem_addr, addr);
    chk({t, ".mem_wen_a"}, ifa.mem_wen, wen);
    chk({t, ".mem_wen_b"}, ifb.mem_wen, wen);
    chk({t, ".mem_wdata_a"}, ifa.mem_wdata, wd);
    chk({t, ".mem_wdata_b"}, ifb.mem_wdata, wd);
    chk({t, ".mem_wmask_a"}, ifa.mem_wmask, wm);
    chk({t, ".mem_wmask_b"}, ifb.mem_wmask, wm);
    chk({t, ".ifu_resp_a"}, ifa.ifu_resp_valid, ir);
    chk({t, ".ifu_resp_b"}, ifb.ifu_resp_valid, ir);
    chk({t, ".lsu_resp_a"}, ifa.lsu_resp_valid, lr);
    chk({t, ".lsu_resp_b"}, ifb.lsu_resp_valid, lr);
    chk({t, ".busy_a"}, busy_a, bsy);
    chk({t, ".busy_b"}, busy_b, bsy);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        mrr;
    logic        mrv;
    logic [31:0] rd;
    logic        e_ird;
    logic        e_lrd;
    logic        e_mrv;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wd;
    logic [3:0]  e_wm;
    logic        e_ir;
    logic        e_lr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // IFU read at N=0, response at N+3; then LSU write with a 1-cycle memory stall,
    // a response coinciding with the REQ handshake (ignored) and a stray response in IDLE.
    vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0010_0073,
                1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hAAAA_5555,
                1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1111_1111,
                1'b0, 1'b0, 1'b0, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0};

    // Reset state.
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_both("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table vectors, one row per clock.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].lv, vecs[i].la, vecs[i].lw, vecs[i].wd,
            vecs[i].wm, vecs[i].mrr, vecs[i].mrv, vecs[i].rd);
      #1;
      check_both($sformatf("vec%0d", i), vecs[i].e_ird, vecs[i].e_lrd, vecs[i].e_mrv,
                 vecs[i].e_addr, vecs[i].e_wen, vecs[i].e_wd, vecs[i].e_wm, vecs[i].e_ir,
                 vecs[i].e_lr, vecs[i].e_busy);
      if (vecs[i].e_ir) chk($sformatf("vec%0d.ifu_rdata", i), ifa.ifu_rdata, vecs[i].rd);
      if (vecs[i].e_lr) chk($sformatf("vec%0d.lsu_rdata", i), ifa.lsu_rdata, vecs[i].rd);
    end

    // Memory holds off 5 cycles: request and payload stay put, LSU is not accepted.
    @(negedge clk);
    drive(1'b1, 32'h8000_2000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("stall.accept_a", ifa.ifu_req_ready, 1'b1);
    chk("stall.accept_b", ifb.ifu_req_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check_both($sformatf("stall%0d", k), 1'b0, 1'b0, 1'b1, 32'h8000_2000, 1'b0, 32'h0,
                 4'h0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("stall.release_a", ifa.mem_req_valid, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    #1;
    chk("stall.resp_a", ifa.ifu_resp_valid, 1'b1);
    chk("stall.resp_b", ifb.ifu_resp_valid, 1'b1);
    chk("stall.rdata_b", ifb.ifu_rdata, 32'hCAFE_F00D);

    // Reset while waiting in RESP; a later stray response must be dropped.
    @(negedge clk);
    drive(1'b1, 32'h8000_4000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rstmid.busy_before", busy_a, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstmid.busy_a", busy_a, 1'b0);
    chk("rstmid.busy_b", busy_b, 1'b0);
    chk("rstmid.addr_a", ifa.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5555_AAAA);
    #1;
    check_both("stray", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Three back-to-back ties (last owner is LSU after reset):
    // fixed priority -> LSU every time, round-robin -> IFU, LSU, IFU.
    for (int t = 0; t < 3; t++) begin
      logic b_ifu;
      b_ifu = (t != 1);
      @(negedge clk);
      drive(1'b1, 32'h8000_5000, 1'b1, 32'h8000_6000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("tie%0d.ifu_ready_a", t), ifa.ifu_req_ready, 1'b0);
      chk($sformatf("tie%0d.lsu_ready_a", t), ifa.lsu_req_ready, 1'b1);
      chk($sformatf("tie%0d.ifu_ready_b", t), ifb.ifu_req_ready, b_ifu);
      chk($sformatf("tie%0d.lsu_ready_b", t), ifb.lsu_req_ready, !b_ifu);
      @(negedge clk);
      drive(1'b1, 32'h8000_5000, 1'b1, 32'h8000_6000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      #1;
      chk($sformatf("tie%0d.addr_a", t), ifa.mem_addr, 32'h8000_6000);
      chk($sformatf("tie%0d.addr_b", t), ifb.mem_addr,
          b_ifu ? 32'h8000_5000 : 32'h8000_6000);
      @(negedge clk);
      drive(1'b1, 32'h8000_5000, 1'b1, 32'h8000_6000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'(t));
      #1;
      chk($sformatf("tie%0d.lsu_resp_a", t), ifa.lsu_resp_valid, 1'b1);
      chk($sformatf("tie%0d.ifu_resp_a", t), ifa.ifu_resp_valid, 1'b0);
      chk($sformatf("tie%0d.ifu_resp_b", t), ifb.ifu_resp_valid, b_ifu);
      chk($sformatf("tie%0d.lsu_resp_b", t), ifb.lsu_resp_valid, !b_ifu);
    end
    @(negedge clk);
    idle_inputs();

`ifdef ARB_TIMEOUT_EN
    // No response: forced error response 4 cycles after entering RESP.
    @(negedge clk);
    drive(1'b1, 32'h8000_7000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("tmo%0d.ifu_resp_a", k), ifa.ifu_resp_valid, k == 4);
      chk($sformatf("tmo%0d.ifu_resp_b", k), ifb.ifu_resp_valid, k == 4);
      chk($sformatf("tmo%0d.err_a", k), err_a, k == 4);
      chk($sformatf("tmo%0d.err_b", k), err_b, k == 4);
      if (k == 4) chk("tmo.rdata_a", ifa.ifu_rdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_8000, 1'b1, 32'h0, 4'h3, 1'b0, 1'b0, 32'h0);
    #1;
    chk("tmo.next_accept_a", ifa.lsu_req_ready, 1'b1);
    chk("tmo.next_accept_b", ifb.lsu_req_ready, 1'b1);
    chk("tmo.err_idle_a", err_a, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("tmo.next_resp_a", ifa.lsu_resp_valid, 1'b1);
    chk("tmo.next_err_a", err_a, 1'b0);
    @(negedge clk);
    idle_inputs();
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
